uart_fifo_ctrl: RTL

Parametrised successor to the single-channel UART peripheral. Adds configurable character width, optional runtime-selected parity, TX and RX FIFOs of configurable depth, FIFO fill levels, and sticky error flags (framing, parity, overrun). Sits on the CPU peripheral bus behind the memory-mapped register decode and connects straight to the pad-level rx/tx lines.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART.
// UART_PARITY_EN adds the PARITY state to both FSM enums.
package uart_pkg;

    localparam int MIN_CLK_PER_BIT = 2;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

    // Mode 11 is deliberately folded into "none".
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        return data_xor ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with registered occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot a same-cycle push needs when full; an empty FIFO cannot pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered UART: TX/RX FIFOs, serial FSMs, rx synchronizer and sticky errors.
// Define UART_PARITY_EN to enable runtime-selected parity; otherwise frames are always no-parity.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     clk_per_bit,
    input  logic [1:0]           parity_mode,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_wr,
    input  logic [DATA_BITS-1:0] tx_wdata,
    output logic                 tx_full,
    output logic [LVL_W-1:0]     tx_level,
    output logic                 tx_busy,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] rx_rdata,
    output logic                 rx_ready,
    output logic [LVL_W-1:0]     rx_level,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    input  logic                 err_clr
);

    localparam int BW = $clog2(DATA_BITS);

    function automatic logic [DIV_W-1:0] clamp_cpb(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(MIN_CLK_PER_BIT)) ? DIV_W'(MIN_CLK_PER_BIT) : v;
    endfunction

    tx_state_t            tx_state;
    logic [DIV_W-1:0]     tx_cnt;
    logic [DIV_W-1:0]     tx_cpb;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BW-1:0]        tx_idx;
    logic                 tx_bit_end;
    logic                 tx_pop;
    logic                 tx_empty;
    logic [DATA_BITS-1:0] tx_head;

    rx_state_t            rx_state;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic [DIV_W-1:0]     rx_cnt;
    logic [DIV_W-1:0]     rx_cpb;
    logic [DATA_BITS-1:0] rx_shift;
    logic [BW-1:0]        rx_idx;
    logic                 rx_sample;
    logic                 rx_half;
    logic                 rx_push;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 par_fail;
    logic                 stop_sample;

`ifdef UART_PARITY_EN
    logic tx_par_en;
    logic tx_par_val;
    logic rx_par_en;
    logic [1:0] rx_par_mode;
    logic rx_par_bad;
    assign par_fail = rx_par_bad;
`else
    logic unused_parity;
    assign unused_parity = ^parity_mode;
    assign par_fail      = 1'b0;
    assign err_parity    = 1'b0;
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_wr),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_rd),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign rx_ready = !rx_empty;
    assign tx_busy  = !tx_empty || (tx_state != TX_IDLE);

    // Popping at the end of the stop bit chains frames with no idle gap.
    assign tx_bit_end = (tx_cnt == tx_cpb - DIV_W'(1));
    assign tx_pop     = !tx_empty &&
                        ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
        end else if (tx_pop) begin
            tx_state <= TX_START;
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_shift <= tx_head;
            tx_cpb   <= clamp_cpb(clk_per_bit);
`ifdef UART_PARITY_EN
            tx_par_en  <= parity_on(parity_mode);
            tx_par_val <= parity_bit(parity_mode, ^tx_head);
`endif
        end else begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + DIV_W'(1);
            case (tx_state)
                TX_IDLE: begin
                    tx     <= 1'b1;
                    tx_cnt <= '0;
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= '0;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                            tx       <= tx_par_en ? tx_par_val : 1'b1;
`else
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
`endif
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_idx   <= tx_idx + BW'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_bit_end) tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // rx_cnt counts cycles since the synchronized falling edge, so the start
    // check lands at half a bit and each later sample one full bit on.
    assign rx_sample   = (rx_cnt >= rx_cpb);
    assign rx_half     = (rx_cnt >= (rx_cpb >> 1));
    assign stop_sample = (rx_state == RX_STOP) && rx_sample;
    assign rx_push     = stop_sample && rx_s2 && !par_fail;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_cnt  <= rx_cnt + DIV_W'(1);
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= DIV_W'(2);
                        rx_cpb   <= clamp_cpb(clk_per_bit);
`ifdef UART_PARITY_EN
                        rx_par_en   <= parity_on(parity_mode);
                        rx_par_mode <= parity_mode;
`endif
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_cnt   <= DIV_W'(1);
                        rx_idx   <= '0;
`ifdef UART_PARITY_EN
                        rx_par_bad <= 1'b0;
`endif
                    end
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        rx_cnt   <= DIV_W'(1);
                        if (rx_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_idx <= rx_idx + BW'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_sample) begin
                        rx_par_bad <= rx_s2 ^ parity_bit(rx_par_mode, ^rx_shift);
                        rx_state   <= RX_STOP;
                        rx_cnt     <= DIV_W'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_sample) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Sticky flags: a fresh error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_PARITY_EN
            err_parity  <= 1'b0;
`endif
        end else begin
            err_frame   <= (stop_sample && !rx_s2) || (err_frame && !err_clr);
            err_overrun <= (rx_push && rx_full && !rx_rd) || (err_overrun && !err_clr);
`ifdef UART_PARITY_EN
            err_parity  <= (stop_sample && par_fail) || (err_parity && !err_clr);
`endif
        end
    end

endmodule
